// File: rtl/ttlock_key_loader_pkg.sv
// ttlock_key_loader_pkg: shared state encoding and default widths for the key loader.
package ttlock_key_loader_pkg;
   localparam int KEY_W_DEF = 32;
   localparam int CNT_W_DEF = 6;
   typedef enum logic [2:0] {IDLE, SHIFT, CHECK, ARMED, ERROR} state_e;
endpackage

// File: rtl/ttlock_key_loader_key_shadow_reg.sv
// key_shadow_reg: serial-to-parallel shadow register with bit counter and running even parity.
module key_shadow_reg #(
   parameter int KEY_W = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_i,
   input  logic             xfer_i,
   input  logic             bit_i,
   output logic [KEY_W-1:0] shadow_o,
   output logic [CNT_W-1:0] cnt_o,
   output logic             last_o,
   output logic             par_ok_o
);
   logic [KEY_W-1:0] shadow_q, shadow_d, we;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             par_q, par_d;
   assign last_o = cnt_q == CNT_W'(KEY_W);
   // one-hot write enable; the parity transfer (cnt==KEY_W) matches no slot
   for (genvar i = 0; i < KEY_W; i++) begin : g_we
      assign we[i] = xfer_i && cnt_q == CNT_W'(i);
   end
   always_comb begin
      shadow_d = clr_i ? '0 : (shadow_q & ~we) | (we & {KEY_W{bit_i}});
      cnt_d    = clr_i ? '0 : (xfer_i && !last_o) ? cnt_q + 1'b1 : cnt_q;
      par_d    = clr_i ? 1'b0 : xfer_i ? par_q ^ bit_i : par_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_q <= '0;
         cnt_q    <= '0;
         par_q    <= 1'b0;
      end else begin
         shadow_q <= shadow_d;
         cnt_q    <= cnt_d;
         par_q    <= par_d;
      end
   end
   assign shadow_o = shadow_q;
   assign cnt_o    = cnt_q;
   assign par_ok_o = !par_q;
endmodule

// File: rtl/ttlock_key_loader.sv
// ttlock_key_loader: loads a serial parity-checked key and drives it to a locked netlist's key inputs.
module ttlock_key_loader
   import ttlock_key_loader_pkg::*;
#(
   parameter int KEY_W = KEY_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_start,
   input  logic             bit_valid,
   input  logic             bit_in,
   output logic             bit_ready,
   output logic [KEY_W-1:0] key_out,
   output logic             key_valid,
   output logic             key_err,
   output logic             busy
);
   state_e           state_q, state_d;
   logic [KEY_W-1:0] key_q, key_d, shadow;
   logic [CNT_W-1:0] cnt;
   logic             xfer, clr, last, par_ok;
   // an abort takes priority over a bit offered in the same cycle
   assign xfer = state_q == SHIFT && bit_valid && !load_start;
   assign clr  = state_d == SHIFT && state_q != SHIFT;
   key_shadow_reg #(.KEY_W(KEY_W), .CNT_W(CNT_W)) u_shadow (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_i    (clr),
      .xfer_i   (xfer),
      .bit_i    (bit_in),
      .shadow_o (shadow),
      .cnt_o    (cnt),
      .last_o   (last),
      .par_ok_o (par_ok)
   );
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, ARMED, ERROR: state_d = load_start ? SHIFT : state_q;
         SHIFT:              state_d = load_start ? ERROR : (xfer && last) ? CHECK : SHIFT;
         CHECK:              state_d = load_start ? ERROR : par_ok ? ARMED : ERROR;
         default:            state_d = IDLE;
      endcase
      key_d = state_d != ARMED ? '0 : state_q == CHECK ? shadow : key_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         key_q   <= '0;
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
      end
   end
   assign bit_ready = state_q == SHIFT;
   assign busy      = state_q == SHIFT || state_q == CHECK;
   assign key_valid = state_q == ARMED;
   assign key_err   = state_q == ERROR;
   assign key_out   = key_q;
endmodule

// File: tb/tb_ttlock_key_loader.sv
// tb_ttlock_key_loader: randomized key loads checked every cycle against a behavioural loader model.
module tb_ttlock_key_loader;
   logic        clk = 1'b0;
   logic        rst_n, load_start, bit_valid, bit_in;
   logic        bit_ready, key_valid, key_err, busy;
   logic [31:0] key_out;
   int          total = 0, bad = 0;
   bit          run = 1'b0;

   ttlock_key_loader dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_start (load_start),
      .bit_valid  (bit_valid),
      .bit_in     (bit_in),
      .bit_ready  (bit_ready),
      .key_out    (key_out),
      .key_valid  (key_valid),
      .key_err    (key_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   typedef enum {M_IDLE, M_SHIFT, M_CHECK, M_ARMED, M_ERR} mode_t;
   mode_t       m;
   int          n;
   logic [31:0] sh, kout;
   logic        mp;

   // model: collect bits into a plain vector, judge parity by population count
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m = M_IDLE; n = 0; sh = 0; kout = 0; mp = 0;
      end else begin
         case (m)
            M_IDLE, M_ARMED, M_ERR:
               if (load_start) begin m = M_SHIFT; n = 0; sh = 0; end
            M_SHIFT:
               if (load_start) m = M_ERR;
               else if (bit_valid) begin
                  if (n < 32) begin sh[n] = bit_in; n++; end
                  else begin mp = bit_in; m = M_CHECK; end
               end
            M_CHECK:
               if (load_start) m = M_ERR;
               else if ((($countones(sh) + int'(mp)) % 2) == 0) begin m = M_ARMED; kout = sh; end
               else m = M_ERR;
            default: m = M_IDLE;
         endcase
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (run) begin
         chk("cyc_bit_ready", 32'(bit_ready), 32'(m == M_SHIFT));
         chk("cyc_busy", 32'(busy), 32'(m == M_SHIFT || m == M_CHECK));
         chk("cyc_key_valid", 32'(key_valid), 32'(m == M_ARMED));
         chk("cyc_key_err", 32'(key_err), 32'(m == M_ERR));
         chk("cyc_key_out", key_out, m == M_ARMED ? kout : 32'h0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
   endtask

   task automatic send(input logic [31:0] k, input logic p, input int maxgap, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         bit_valid = 1'b0;
         repeat (maxgap > 0 ? $urandom_range(0, maxgap) : 0) begin
            bit_in = 1'($urandom);
            tick();
         end
         bit_in    = i < 32 ? k[i] : p;
         bit_valid = 1'b1;
         tick();
      end
      bit_valid = 1'b0;
   endtask

   task automatic noise(input int cycles);
      repeat (cycles) begin
         bit_valid = 1'($urandom);
         bit_in    = 1'($urandom);
         tick();
      end
      bit_valid = 1'b0;
   endtask

   initial begin
      logic [31:0] k;
      logic        p;
      int          kind;
      rst_n = 1'b0; load_start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_key_out", key_out, 32'h0);
      chk("rst_flags", {28'h0, bit_ready, key_valid, key_err, busy}, 32'h0);
      rst_n = 1'b1;
      run   = 1'b1;
      noise(4);
      chk("idle_ignore_bits", 32'(bit_ready), 32'h0);
      // clean load, parity 0 is correct for 0xA5A50F0F
      pulse_start();
      send(32'hA5A5_0F0F, 1'b0, 0, 33);
      chk("a5_check_busy", 32'(busy), 32'h1);
      chk("a5_check_not_valid", 32'(key_valid), 32'h0);
      tick();
      chk("a5_valid", 32'(key_valid), 32'h1);
      chk("a5_key", key_out, 32'hA5A5_0F0F);
      chk("a5_no_err", 32'(key_err), 32'h0);
      // restart from ARMED drops the key on the same edge
      pulse_start();
      chk("rearm_valid_low", 32'(key_valid), 32'h0);
      chk("rearm_key_zero", key_out, 32'h0);
      chk("rearm_ready", 32'(bit_ready), 32'h1);
      send(32'h0000_0001, 1'b0, 0, 33);
      tick();
      chk("bad_par_err", 32'(key_err), 32'h1);
      chk("bad_par_key", key_out, 32'h0);
      chk("bad_par_valid", 32'(key_valid), 32'h0);
      // stalled load
      pulse_start();
      send(32'hDEAD_BEEF, 1'b0, 5, 33);
      tick();
      chk("stall_valid", 32'(key_valid), 32'h1);
      chk("stall_key", key_out, 32'hDEAD_BEEF);
      // abort after 17 bits, then a good load
      pulse_start();
      send(32'hFFFF_FFFF, 1'b0, 1, 17);
      pulse_start();
      chk("abort_err", 32'(key_err), 32'h1);
      chk("abort_key", key_out, 32'h0);
      pulse_start();
      send(32'h1234_5678, 1'b1, 3, 33);
      tick();
      chk("after_abort_key", key_out, 32'h1234_5678);
      chk("after_abort_valid", 32'(key_valid), 32'h1);
      // asynchronous reset partway through a load
      pulse_start();
      send(32'h8765_4321, 1'b0, 1, 20);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_key", key_out, 32'h0);
      chk("async_rst_flags", {28'h0, bit_ready, key_valid, key_err, busy}, 32'h0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      bit_valid = 1'b1;
      repeat (5) begin
         bit_in = 1'($urandom);
         tick();
      end
      bit_valid = 1'b0;
      chk("post_rst_idle_ready", 32'(bit_ready), 32'h0);
      chk("post_rst_idle_busy", 32'(busy), 32'h0);
      pulse_start();
      send(32'h1234_5678, 1'b1, 0, 33);
      tick();
      chk("post_rst_key", key_out, 32'h1234_5678);
      // randomized loads, parity errors and aborts in SHIFT or CHECK
      for (int it = 0; it < 40; it++) begin
         k    = $urandom;
         p    = ($urandom_range(0, 3) == 0) ? 1'($urandom) : ^k;
         kind = $urandom_range(0, 5);
         noise($urandom_range(0, 4));
         pulse_start();
         if (kind == 0) begin
            send(k, p, 2, $urandom_range(1, 32));
            pulse_start();
         end else if (kind == 1) begin
            send(k, p, 2, 33);
            pulse_start();
         end else begin
            send(k, p, 3, 33);
            tick();
         end
         noise(2);
      end
      run = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
